// File: rtl/sdram_pkg.sv
// Shared width defaults and FSM state encoding for the SDRAM arbiter.
package sdram_pkg;

  localparam int unsigned ADDR_W_DEF = 24;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin tie-break: a tie goes to the requester not served last.
module rr_arb2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] gnt_c
);

  // One-hot grant; a lone request wins regardless of history
  always_comb begin
    gnt_c = 2'b00;
    if (req0 && req1) begin
      gnt_c = last ? 2'b01 : 2'b10;
    end else if (req0) begin
      gnt_c = 2'b01;
    end else if (req1) begin
      gnt_c = 2'b10;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester arbiter in front of an SDRAM controller: one access at a time,
// round-robin on ties, bounded wait for completion.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [1:0]         arb_gnt_c;

  logic               r0_gnt_d, r1_gnt_d, r0_done_d, r1_done_d;
  logic               mem_req_d, mem_we_d, err_timeout_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_d, r0_rdata_d, r1_rdata_d;

  rr_arb2 u_arb (
    .req0  (r0_req),
    .req1  (r1_req),
    .last  (last_q),
    .gnt_c (arb_gnt_c)
  );

  // Next-state and next-output logic; command regs only load on IDLE exit
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    last_d        = last_q;
    mem_we_d      = mem_we;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    r0_rdata_d    = r0_rdata;
    r1_rdata_d    = r1_rdata;
    r0_gnt_d      = 1'b0;
    r1_gnt_d      = 1'b0;
    r0_done_d     = 1'b0;
    r1_done_d     = 1'b0;
    mem_req_d     = 1'b0;
    err_timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_gnt_c != 2'b00) begin
          owner_d     = arb_gnt_c[1];
          mem_we_d    = arb_gnt_c[1] ? r1_we    : r0_we;
          mem_addr_d  = arb_gnt_c[1] ? r1_addr  : r0_addr;
          mem_wdata_d = arb_gnt_c[1] ? r1_wdata : r0_wdata;
          r0_gnt_d    = arb_gnt_c[0];
          r1_gnt_d    = arb_gnt_c[1];
          mem_req_d   = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          if (!mem_we) begin
            if (owner_q) r1_rdata_d = mem_rdata;
            else         r0_rdata_d = mem_rdata;
          end
          r0_done_d = ~owner_q;
          r1_done_d = owner_q;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          r0_done_d     = ~owner_q;
          r1_done_d     = owner_q;
          err_timeout_d = 1'b1;
          state_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, command and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      r0_gnt      <= 1'b0;
      r1_gnt      <= 1'b0;
      r0_done     <= 1'b0;
      r1_done     <= 1'b0;
      r0_rdata    <= '0;
      r1_rdata    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      r0_gnt      <= r0_gnt_d;
      r1_gnt      <= r1_gnt_d;
      r0_done     <= r0_done_d;
      r1_done     <= r1_done_d;
      r0_rdata    <= r0_rdata_d;
      r1_rdata    <= r1_rdata_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      err_timeout <= err_timeout_d;
    end
  end

endmodule
